// File: rtl/multi_evt_counter.sv
// NUM_CH independent event counters sharing a programmable terminal count, with wrap/saturate mode,
// per-channel clear, wrap pulses, sticky saturation flags and an atomic snapshot. Counts update one cycle after the strobe.
module multi_evt_counter #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_MAX = 40000
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    en_in,
    input  logic [NUM_CH-1:0]       evt_in,
    input  logic [NUM_CH-1:0]       clr_in,
    input  logic [WIDTH-1:0]        max_count_in,
    input  logic                    max_load_in,
    input  logic                    sat_mode_in,
    input  logic                    snap_in,
    output logic [NUM_CH*WIDTH-1:0] count_out,
    output logic [NUM_CH*WIDTH-1:0] snap_out,
    output logic                    snap_valid_out,
    output logic [NUM_CH-1:0]       wrap_out,
    output logic [NUM_CH-1:0]       sat_out,
    output logic [WIDTH-1:0]        max_out
);

    logic [WIDTH-1:0]  cnt_q  [NUM_CH];
    logic [WIDTH-1:0]  cnt_d  [NUM_CH];
    logic [WIDTH-1:0]  snap_q [NUM_CH];
    logic [WIDTH-1:0]  snap_d [NUM_CH];
    logic [NUM_CH-1:0] wrap_q, wrap_d;
    logic [NUM_CH-1:0] sat_q, sat_d;
    logic [WIDTH-1:0]  max_q, max_d;
    logic              snap_vld_q, snap_vld_d;

    always_comb begin
        max_d      = max_load_in ? max_count_in : max_q;
        snap_vld_d = snap_in;
        wrap_d     = '0;
        sat_d      = sat_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            // Snapshot takes the pre-edge count, so same-cycle events/clears never leak into it.
            snap_d[i] = snap_in ? cnt_q[i] : snap_q[i];
            if (clr_in[i]) begin
                cnt_d[i] = '0;
                sat_d[i] = 1'b0;
            end else if (en_in && evt_in[i]) begin
                // >= keeps a counter from running past a freshly lowered terminal count.
                if (cnt_q[i] < max_q) begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end else if (sat_mode_in) begin
                    sat_d[i] = 1'b1;
                end else begin
                    cnt_d[i]  = '0;
                    wrap_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
            wrap_q     <= '0;
            sat_q      <= '0;
            max_q      <= WIDTH'(DEFAULT_MAX);
            snap_vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                snap_q[i] <= snap_d[i];
            end
            wrap_q     <= wrap_d;
            sat_q      <= sat_d;
            max_q      <= max_d;
            snap_vld_q <= snap_vld_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign count_out[g*WIDTH +: WIDTH] = cnt_q[g];
        assign snap_out[g*WIDTH +: WIDTH]  = snap_q[g];
    end

    assign snap_valid_out = snap_vld_q;
    assign wrap_out       = wrap_q;
    assign sat_out        = sat_q;
    assign max_out        = max_q;

endmodule
